// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory end of the cache->memory request interface. It gives a single cache
//   a backing store with fixed, cycle-accurate latency, so the cache can be
//   exercised without any bus arbitration in front of it.
//
//   Parameters
//     LATENCY        cycles from request acceptance to response pulse (1..255)
//     DEPTH          number of memory words (power of two); the address wraps
//                    on its low log2(DEPTH) bits
//     IOSTATE_WIDTH  width of the request-type code
//     ADDR_WIDTH     request address width
//     WORD_WIDTH     data word width
//     RW_IDLE/RW_READ/RW_WRITE  request-type codes; unknown codes act as idle
//
//   Ports
//     clk            system clock, everything on the rising edge
//     reset          synchronous, active-high
//     rwFromCache    request type, held by the cache until it sees a response
//     addrFromCache  request address
//     dataFromCache  write-back data
//     dataToCache    read data, holds the last read value
//     rdEnToCache    one-cycle pulse: dataToCache carries the read response
//     wbDoneToCache  one-cycle pulse: the write has been committed
//     debugState     FSM state (0 IDLE, 1 BUSY, 2 RESP, 3 WAITIDLE)
//     debugDelay     remaining latency count
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int LATENCY       = 8,
  parameter int DEPTH         = 16,
  parameter int IOSTATE_WIDTH = 2,
  parameter int ADDR_WIDTH    = 16,
  parameter int WORD_WIDTH    = 32,
  parameter logic [IOSTATE_WIDTH-1:0] RW_IDLE  = 2'd0,
  parameter logic [IOSTATE_WIDTH-1:0] RW_READ  = 2'd1,
  parameter logic [IOSTATE_WIDTH-1:0] RW_WRITE = 2'd2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IOSTATE_WIDTH-1:0] rwFromCache,
  input  logic [ADDR_WIDTH-1:0]    addrFromCache,
  input  logic [WORD_WIDTH-1:0]    dataFromCache,
  output logic [WORD_WIDTH-1:0]    dataToCache,
  output logic                     rdEnToCache,
  output logic                     wbDoneToCache,
  output logic [1:0]               debugState,
  output logic [7:0]               debugDelay
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY     = 2'd1,
    S_RESP     = 2'd2,
    S_WAITIDLE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic                    is_read_reg, is_read_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [WORD_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [WORD_WIDTH-1:0]   rdata_reg;
  logic                    rd_en_reg, wb_done_reg;

  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  logic                    req_active;
  logic                    fire;
  logic [IDX_W-1:0]        idx;

  // Only the two real request codes count; anything else behaves as idle,
  // both for acceptance and for aborting an in-flight request.
  assign req_active = (rwFromCache == RW_READ) || (rwFromCache == RW_WRITE);

  // The response edge: last BUSY cycle with the request still held.
  assign fire = (state_reg == S_BUSY) && req_active && (cnt_reg == 8'd0);
  assign idx  = addr_reg[IDX_W-1:0];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    is_read_next = is_read_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_active) begin
          is_read_next = (rwFromCache == RW_READ);
          addr_next    = addrFromCache;
          wdata_next   = dataFromCache;
          cnt_next     = LAT_M1;
          state_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!req_active) begin
          // Cache withdrew the request: drop it silently.
          cnt_next   = 8'd0;
          state_next = S_IDLE;
        end else if (cnt_reg == 8'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      // Dropping rw during the pulse cycle lets the next request be accepted
      // LATENCY+2 cycles after the previous one; otherwise wait for idle so a
      // still-held request is not served twice.
      S_RESP: begin
        state_next = req_active ? S_WAITIDLE : S_IDLE;
      end
      S_WAITIDLE: begin
        if (!req_active) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      is_read_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      is_read_reg <= is_read_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

  // Storage is never cleared; a write landing on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (!reset && fire && !is_read_reg) begin
      mem[idx] <= wdata_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_reg   <= 1'b0;
      wb_done_reg <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      rd_en_reg   <= fire && is_read_reg;
      wb_done_reg <= fire && !is_read_reg;
      if (fire && is_read_reg) begin
        rdata_reg <= mem[idx];
      end
    end
  end

  assign dataToCache   = rdata_reg;
  assign rdEnToCache   = rd_en_reg;
  assign wbDoneToCache = wb_done_reg;
  assign debugState    = state_reg;
  assign debugDelay    = cnt_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int LAT = 8;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_READ  = 2'd1;
  localparam logic [1:0] R_WRITE = 2'd2;

  logic        clk;
  logic        reset;
  logic [1:0]  rw, rw1;
  logic [15:0] addr, addr1;
  logic [31:0] data, data1;
  logic [31:0] d_out, d_out1;
  logic        rd_en, rd_en1, wb_done, wb_done1;
  logic [1:0]  dbg_state, dbg_state1;
  logic [7:0]  dbg_delay, dbg_delay1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference: plain word array indexed by address mod 16, plus the value
  // the read port should currently be showing.
  logic [31:0] model_mem [16];
  logic [31:0] last_rd;

  mem_responder #(.LATENCY(LAT), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rwFromCache(rw), .addrFromCache(addr),
    .dataFromCache(data), .dataToCache(d_out), .rdEnToCache(rd_en),
    .wbDoneToCache(wb_done), .debugState(dbg_state), .debugDelay(dbg_delay)
  );

  mem_responder #(.LATENCY(1), .DEPTH(16)) dut1 (
    .clk(clk), .reset(reset), .rwFromCache(rw1), .addrFromCache(addr1),
    .dataFromCache(data1), .dataToCache(d_out1), .rdEnToCache(rd_en1),
    .wbDoneToCache(wb_done1), .debugState(dbg_state1), .debugDelay(dbg_delay1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request on the latency-8 instance: accept, wait for the pulse,
  // optionally keep holding the request, then release for one cycle.
  task automatic txn(input logic [1:0] kind, input logic [15:0] a,
                     input logic [31:0] d, input int hold, input string tag);
    int k;
    int extra;
    bit got;
    logic [31:0] exp_d;
    rw = kind; addr = a; data = d;
    tick();
    tests_run++;
    if (dbg_state !== 2'd1 || dbg_delay !== 8'(LAT - 1)) begin
      tests_failed++;
      $display("FAIL %s accept: state=%0d delay=%0d expected state=1 delay=%0d",
               tag, dbg_state, dbg_delay, LAT - 1);
    end
    got = 0; k = 0;
    while (!got && k < LAT + 4) begin
      tick(); k++;
      if (rd_en === 1'b1 || wb_done === 1'b1) got = 1;
    end
    tests_run++;
    if (!got || k != LAT) begin
      tests_failed++;
      $display("FAIL %s latency: pulse at %0d (seen=%0d) expected %0d", tag, k, got, LAT);
    end
    if (kind == R_READ) begin
      exp_d = model_mem[a[3:0]];
      last_rd = exp_d;
      tests_run++;
      if (rd_en !== 1'b1 || wb_done !== 1'b0 || d_out !== exp_d) begin
        tests_failed++;
        $display("FAIL %s read a=%0d: rd=%0b wb=%0b data=%0h expected rd=1 wb=0 data=%0h",
                 tag, a, rd_en, wb_done, d_out, exp_d);
      end
    end else begin
      model_mem[a[3:0]] = d;
      tests_run++;
      if (wb_done !== 1'b1 || rd_en !== 1'b0 || d_out !== last_rd) begin
        tests_failed++;
        $display("FAIL %s write a=%0d: wb=%0b rd=%0b data=%0h expected wb=1 rd=0 data=%0h",
                 tag, a, wb_done, rd_en, d_out, last_rd);
      end
    end
    if (hold > 0) begin
      extra = 0;
      repeat (hold) begin
        tick();
        if (rd_en !== 1'b0 || wb_done !== 1'b0) extra++;
      end
      tests_run++;
      if (extra != 0 || dbg_state !== 2'd3) begin
        tests_failed++;
        $display("FAIL %s hold: extra pulses=%0d state=%0d expected 0 pulses state=3",
                 tag, extra, dbg_state);
      end
    end
    rw = R_IDLE;
    tick();
    tests_run++;
    if (rd_en !== 1'b0 || wb_done !== 1'b0 || dbg_state !== 2'd0 || d_out !== last_rd) begin
      tests_failed++;
      $display("FAIL %s release: rd=%0b wb=%0b state=%0d data=%0h expected 0 0 0 %0h",
               tag, rd_en, wb_done, dbg_state, d_out, last_rd);
    end
    $display("[TB] %s kind=%0d addr=%0d data=%0h pulse_at=%0d hold=%0d", tag, kind, a, d, k, hold);
  endtask

  // Watch for any stray pulse over n cycles with no live request.
  task automatic quiet(input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      tick();
      if (rd_en !== 1'b0 || wb_done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL %s quiet: pulses=%0d state=%0d expected 0 and 0", tag, bad, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rw = R_IDLE; rw1 = R_IDLE;
    tick(); tick();
    tests_run++;
    if (rd_en !== 1'b0 || wb_done !== 1'b0 || d_out !== 32'd0 ||
        dbg_state !== 2'd0 || dbg_delay !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset: rd=%0b wb=%0b data=%0h state=%0d delay=%0d expected all 0",
               rd_en, wb_done, d_out, dbg_state, dbg_delay);
    end
    reset = 1'b0;
    last_rd = 32'd0;
    tick();
    $display("[TB] reset released");
  endtask

  task automatic test_basic();
    txn(R_WRITE, 16'd0, 32'd5, 0, "preload0");
    txn(R_READ,  16'd0, 32'd0, 0, "read0");
    txn(R_WRITE, 16'd3, 32'd9, 0, "write3");
    txn(R_WRITE, 16'd1, 32'h11, 0, "preload1");
    txn(R_WRITE, 16'd2, 32'h22, 0, "preload2");
    txn(R_READ,  16'd3, 32'd0, 0, "read3");
  endtask

  task automatic test_hold();
    txn(R_READ, 16'd0, 32'd0, 5, "hold_read");
    txn(R_READ, 16'd3, 32'd0, 0, "reaccept");
  endtask

  task automatic test_abort();
    rw = R_WRITE; addr = 16'd1; data = 32'd7;
    tick();              // accept edge N
    tick(); tick();      // N+1, N+2
    rw = R_IDLE;
    tick();              // N+3 sees idle
    quiet(LAT + 4, "abort");
    txn(R_READ, 16'd1, 32'd0, 0, "abort_check");
  endtask

  task automatic test_reset_mid();
    rw = R_WRITE; addr = 16'd2; data = 32'hDEAD;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();              // reset at N+4
    tests_run++;
    if (dbg_state !== 2'd0 || rd_en !== 1'b0 || wb_done !== 1'b0 || d_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: state=%0d rd=%0b wb=%0b data=%0h expected 0 0 0 0",
               dbg_state, rd_en, wb_done, d_out);
    end
    reset = 1'b0; rw = R_IDLE; last_rd = 32'd0;
    quiet(LAT + 4, "reset_mid");
    txn(R_READ, 16'd2, 32'd0, 0, "reset_mid_a2");
    txn(R_READ, 16'd3, 32'd0, 0, "reset_mid_a3");
    // Reset landing exactly on the response edge must not commit the write.
    rw = R_WRITE; addr = 16'd0; data = 32'hBEEF;
    tick();
    repeat (LAT - 1) tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (rd_en !== 1'b0 || wb_done !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_resp: rd=%0b wb=%0b state=%0d expected 0 0 0",
               rd_en, wb_done, dbg_state);
    end
    reset = 1'b0; rw = R_IDLE; last_rd = 32'd0;
    tick();
    txn(R_READ, 16'd0, 32'd0, 0, "reset_resp_a0");
  endtask

  task automatic test_wrap();
    txn(R_READ,  16'd17, 32'd0, 0, "wrap_read17");
    txn(R_WRITE, 16'd34, 32'h1234, 0, "wrap_write34");
    txn(R_READ,  16'd2, 32'd0, 0, "wrap_read2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      txn(R_WRITE, 16'(i), $urandom, 0, "rnd_init");
    end
    for (int i = 0; i < 40; i++) begin
      txn(($urandom_range(0, 1) == 0) ? R_READ : R_WRITE, 16'($urandom_range(0, 63)),
          $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, "rnd");
    end
  endtask

  task automatic test_latency1();
    rw1 = R_WRITE; addr1 = 16'd5; data1 = 32'hA5;
    tick();
    tests_run++;
    if (dbg_state1 !== 2'd1 || dbg_delay1 !== 8'd0 || wb_done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat1 accept: state=%0d delay=%0d wb=%0b expected 1 0 0",
               dbg_state1, dbg_delay1, wb_done1);
    end
    tick();
    tests_run++;
    if (wb_done1 !== 1'b1 || rd_en1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat1 write: wb=%0b rd=%0b expected 1 0", wb_done1, rd_en1);
    end
    rw1 = R_IDLE;
    tick();
    rw1 = R_READ; addr1 = 16'd21;
    tick();
    tick();
    tests_run++;
    if (rd_en1 !== 1'b1 || d_out1 !== 32'hA5) begin
      tests_failed++;
      $display("FAIL lat1 read: rd=%0b data=%0h expected 1 a5", rd_en1, d_out1);
    end
    rw1 = R_IDLE;
    tick();
    $display("[TB] latency1 write a=5 then read a=21 data=%0h", d_out1);
  endtask

  initial begin
    reset = 1'b1;
    rw = R_IDLE;  addr = '0;  data = '0;
    rw1 = R_IDLE; addr1 = '0; data1 = '0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_random();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
